// File: rtl/cv32e40p_clock_gate_ctrl.sv
// -----------------------------------------------------------------------------
// cv32e40p_clock_gate_ctrl
//
// Purpose:
//   Decides when the core clock may be gated while the core sits in WFI.
//   After the core asks to sleep and has been quiet for idle_thresh_i cycles,
//   the clock enable drops. A wake request (or loss of permission) starts a
//   short WAKE settle window, after which the core runs again and a one-cycle
//   wake_ack_o pulse tells it the clock is stable. A saturating counter
//   reports how many cycles were spent gated.
//
// Ports:
//   clk_i            free-running (ungated) clock
//   rst_ni           synchronous active-low reset
//   core_sleep_req_i core is in WFI and requests sleep
//   core_busy_i      core has outstanding activity; gating forbidden
//   wake_req_i       pending interrupt or debug request
//   gate_allow_i     global enable for clock gating
//   idle_thresh_i    idle cycles required before gating (sampled every cycle)
//   clear_cnt_i      synchronous clear of sleep_cycles_o
//   clk_en_o         enable to the downstream clock gate (flop output)
//   gated_o          core clock is currently gated
//   wake_ack_o       single-cycle pulse once the woken clock is stable
//   sleep_cycles_o   saturating count of GATED cycles
//   dbg_state_o      current FSM state, for observation only
//
// Interface semantics: this block has no valid/ready handshake. All inputs
// are level signals sampled on every rising clk_i edge; all outputs are
// registered and change only on rising clk_i edges.
// -----------------------------------------------------------------------------
module cv32e40p_clock_gate_ctrl #(
  parameter int IDLE_W   = 4,
  parameter int WAKE_DLY = 2,
  parameter int CNT_W    = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              core_sleep_req_i,
  input  logic              core_busy_i,
  input  logic              wake_req_i,
  input  logic              gate_allow_i,
  input  logic [IDLE_W-1:0] idle_thresh_i,
  input  logic              clear_cnt_i,
  output logic              clk_en_o,
  output logic              gated_o,
  output logic              wake_ack_o,
  output logic [CNT_W-1:0]  sleep_cycles_o,
  output logic [1:0]        dbg_state_o
);

  // FSM encoding
  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_IDLE_CNT = 2'd1;
  localparam logic [1:0] ST_GATED    = 2'd2;
  localparam logic [1:0] ST_WAKE     = 2'd3;

  // WAKE_DLY is limited to 0..15, so a 4-bit wake counter always suffices.
  localparam logic [3:0] WAKE_DLY_C = 4'(WAKE_DLY);

  localparam logic [IDLE_W-1:0] IDLE_MAX = '1;
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  logic [1:0]        state_q,     state_d;
  logic [IDLE_W-1:0] idle_cnt_q,  idle_cnt_d;
  logic [3:0]        wake_cnt_q,  wake_cnt_d;
  logic              wake_pend_q, wake_pend_d;
  logic [CNT_W-1:0]  sleep_cnt_q, sleep_cnt_d;
  logic              clk_en_q;
  logic              gated_q;
  logic              wake_ack_q;

  // All conditions that allow the idle count to proceed; losing any of them
  // while counting aborts back to RUN.
  logic enter_ok;
  assign enter_ok = gate_allow_i & core_sleep_req_i & ~core_busy_i & ~wake_req_i;

  // In GATED the core is asleep, so core_busy_i is deliberately not part of
  // the exit condition.
  logic gated_exit;
  assign gated_exit = wake_req_i | ~gate_allow_i | ~core_sleep_req_i;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    idle_cnt_d  = idle_cnt_q;
    wake_cnt_d  = wake_cnt_q;
    wake_pend_d = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (enter_ok) begin
          state_d    = ST_IDLE_CNT;
          idle_cnt_d = '0;
        end
      end

      ST_IDLE_CNT: begin
        // Abort wins over reaching the threshold on the same edge.
        if (!enter_ok) begin
          state_d = ST_RUN;
        end else if (idle_cnt_q >= idle_thresh_i) begin
          state_d = ST_GATED;
        end else if (idle_cnt_q != IDLE_MAX) begin
          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end

      ST_GATED: begin
        if (gated_exit) begin
          state_d    = ST_WAKE;
          wake_cnt_d = '0;
        end
      end

      ST_WAKE: begin
        // wake_req_i is not looked at here: the settle window always runs to
        // completion and always ends in RUN.
        if (wake_cnt_q == WAKE_DLY_C) begin
          state_d     = ST_RUN;
          wake_pend_d = 1'b1;
        end else begin
          wake_cnt_d = wake_cnt_q + 4'd1;
        end
      end

      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Sleep cycle counter: clear has priority, then saturating increment.
  always_comb begin
    sleep_cnt_d = sleep_cnt_q;
    if (clear_cnt_i) begin
      sleep_cnt_d = '0;
    end else if ((state_q == ST_GATED) && (sleep_cnt_q != CNT_MAX)) begin
      sleep_cnt_d = sleep_cnt_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequential logic
  // ---------------------------------------------------------------------------
  // The outputs are decoded from state_q into their own flops, so clk_en_o is
  // a bare flop output with no combinational path from any input. The cost is
  // one cycle of lag between the state register and the visible outputs.
  // wake_pend_q marks the WAKE->RUN edge; wake_ack_q follows it one cycle
  // later so the pulse lines up with the first visible RUN cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= ST_RUN;
      idle_cnt_q  <= '0;
      wake_cnt_q  <= '0;
      wake_pend_q <= 1'b0;
      sleep_cnt_q <= '0;
      clk_en_q    <= 1'b1;
      gated_q     <= 1'b0;
      wake_ack_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idle_cnt_q  <= idle_cnt_d;
      wake_cnt_q  <= wake_cnt_d;
      wake_pend_q <= wake_pend_d;
      sleep_cnt_q <= sleep_cnt_d;
      clk_en_q    <= (state_q != ST_GATED);
      gated_q     <= (state_q == ST_GATED);
      wake_ack_q  <= wake_pend_q;
    end
  end

  assign clk_en_o       = clk_en_q;
  assign gated_o        = gated_q;
  assign wake_ack_o     = wake_ack_q;
  assign sleep_cycles_o = sleep_cnt_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_cv32e40p_clock_gate_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for cv32e40p_clock_gate_ctrl.
// Two instances share all inputs: one with CNT_W=16 (default) and one with
// CNT_W=4 to exercise sleep counter saturation.
// -----------------------------------------------------------------------------
module tb_cv32e40p_clock_gate_ctrl;

  localparam int IDLE_W   = 4;
  localparam int WAKE_DLY = 2;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic              clk = 1'b0;
  logic              rst_n;
  logic              sleep_req, busy, wake_req, allow, clear_cnt;
  logic [IDLE_W-1:0] thresh;

  logic        clk_en, gated, wake_ack;
  logic [15:0] cnt;
  logic [1:0]  dbg_state;
  logic        clk_en2, gated2, wake_ack2;
  logic [3:0]  cnt2;
  logic [1:0]  dbg_state2;

  always #5 clk = ~clk;

  cv32e40p_clock_gate_ctrl #(.IDLE_W(IDLE_W), .WAKE_DLY(WAKE_DLY), .CNT_W(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .core_sleep_req_i(sleep_req), .core_busy_i(busy),
    .wake_req_i(wake_req), .gate_allow_i(allow), .idle_thresh_i(thresh),
    .clear_cnt_i(clear_cnt), .clk_en_o(clk_en), .gated_o(gated),
    .wake_ack_o(wake_ack), .sleep_cycles_o(cnt), .dbg_state_o(dbg_state)
  );

  cv32e40p_clock_gate_ctrl #(.IDLE_W(IDLE_W), .WAKE_DLY(WAKE_DLY), .CNT_W(4)) dut_sat (
    .clk_i(clk), .rst_ni(rst_n), .core_sleep_req_i(sleep_req), .core_busy_i(busy),
    .wake_req_i(wake_req), .gate_allow_i(allow), .idle_thresh_i(thresh),
    .clear_cnt_i(clear_cnt), .clk_en_o(clk_en2), .gated_o(gated2),
    .wake_ack_o(wake_ack2), .sleep_cycles_o(cnt2), .dbg_state_o(dbg_state2)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard bookkeeping
  // ---------------------------------------------------------------------------
  int tests  = 0;
  int failed = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: a phase name plus plain integer counters. The visible
  // outputs describe the phase the block was in one cycle earlier, so the
  // model keeps the phase before the current edge and the one before that.
  // The sleep count is an unbounded total since the last clear/reset, clipped
  // to each instance's maximum when compared.
  // ---------------------------------------------------------------------------
  typedef enum int {P_RUN, P_IDLE, P_GATED, P_WAKE} phase_e;

  phase_e      m_phase, m_last;
  int          m_idle, m_wake;
  int unsigned m_total;
  int          e_clk_en, e_gated, e_ack;

  function automatic int clip(input int unsigned v, input int unsigned mx);
    return (v > mx) ? int'(mx) : int'(v);
  endfunction

  task automatic model_edge();
    phase_e old;
    bit     ok;
    if (!rst_n) begin
      m_phase = P_RUN; m_last = P_RUN;
      m_idle = 0; m_wake = 0; m_total = 0;
      e_clk_en = 1; e_gated = 0; e_ack = 0;
      return;
    end
    old      = m_phase;
    e_clk_en = (old != P_GATED);
    e_gated  = (old == P_GATED);
    e_ack    = (old == P_RUN && m_last == P_WAKE);
    if (clear_cnt) m_total = 0;
    else if (old == P_GATED) m_total++;
    ok = allow && sleep_req && !busy && !wake_req;
    case (old)
      P_RUN:   if (ok) begin m_phase = P_IDLE; m_idle = 0; end
      P_IDLE: begin
        if (!ok) m_phase = P_RUN;
        else if (m_idle >= int'(thresh)) m_phase = P_GATED;
        else if (m_idle < (1 << IDLE_W) - 1) m_idle++;
      end
      P_GATED: if (wake_req || !allow || !sleep_req) begin m_phase = P_WAKE; m_wake = 0; end
      P_WAKE: begin
        if (m_wake == WAKE_DLY) m_phase = P_RUN;
        else m_wake++;
      end
      default: m_phase = P_RUN;
    endcase
    m_last = old;
  endtask

  task automatic model_compare();
    check("model_clk_en",   int'(clk_en),   e_clk_en);
    check("model_gated",    int'(gated),    e_gated);
    check("model_wake_ack", int'(wake_ack), e_ack);
    check("model_cnt16",    int'(cnt),      clip(m_total, 65535));
    check("model_cnt4",     int'(cnt2),     clip(m_total, 15));
    check("model_clk_en4",  int'(clk_en2),  e_clk_en);
  endtask

  // ---------------------------------------------------------------------------
  // Driver: apply one cycle of inputs, advance one edge, sample #1 later.
  // ---------------------------------------------------------------------------
  task automatic step(input logic r, input logic s, input logic b, input logic w,
                      input logic a, input logic [IDLE_W-1:0] t, input logic c);
    rst_n = r; sleep_req = s; busy = b; wake_req = w; allow = a;
    thresh = t; clear_cnt = c;
    @(posedge clk);
    model_edge();
    #1;
    model_compare();
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table: basic gating with threshold 3, then a wake with
  // WAKE_DLY=2. Row n = inputs before edge n, outputs expected after edge n.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic              s, b, w, a;
    logic [IDLE_W-1:0] t;
    logic              c;
    int                clk_en, gated, ack, cnt;
  } vec_t;

  vec_t tbl[13];

  initial begin
    // Fill table
    for (int i = 0; i < 7; i++) tbl[i] = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0, 1, 0, 0, 0};
    tbl[5].clk_en = 0; tbl[5].gated = 1; tbl[5].cnt = 1;
    tbl[6].clk_en = 0; tbl[6].gated = 1; tbl[6].cnt = 2;
    tbl[7] = '{1'b1, 1'b0, 1'b1, 1'b1, 4'd3, 1'b0, 0, 1, 0, 3};
    for (int i = 8; i < 13; i++) tbl[i] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0, 1, 0, 0, 3};
    tbl[11].ack = 1;

    // Reset and reset-state check
    step(0, 0, 0, 0, 1, 4'd3, 1);
    step(0, 1, 0, 0, 1, 4'd3, 0);
    check("reset_clk_en", int'(clk_en),   1);
    check("reset_gated",  int'(gated),    0);
    check("reset_ack",    int'(wake_ack), 0);
    check("reset_cnt",    int'(cnt),      0);

    // Table-driven gating + wake sequence
    for (int i = 0; i < 13; i++) begin
      step(1, tbl[i].s, tbl[i].b, tbl[i].w, tbl[i].a, tbl[i].t, tbl[i].c);
      check($sformatf("tbl%0d_clk_en", i), int'(clk_en),   tbl[i].clk_en);
      check($sformatf("tbl%0d_gated", i),  int'(gated),    tbl[i].gated);
      check($sformatf("tbl%0d_ack", i),    int'(wake_ack), tbl[i].ack);
      check($sformatf("tbl%0d_cnt", i),    int'(cnt),      tbl[i].cnt);
    end

    // Abort on the threshold edge: busy pulses exactly when idle count hits 2
    step(0, 0, 0, 0, 1, 4'd2, 0);
    step(1, 1, 0, 0, 1, 4'd2, 0);
    step(1, 1, 0, 0, 1, 4'd2, 0);
    step(1, 1, 0, 0, 1, 4'd2, 0);
    check("abort_clk_en_a", int'(clk_en), 1);
    step(1, 1, 1, 0, 1, 4'd2, 0);
    check("abort_clk_en_b", int'(clk_en), 1);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 0, 0, 1, 4'd2, 0);
      check("abort_clk_en", int'(clk_en), 1);
      check("abort_gated",  int'(gated),  0);
    end
    check("abort_cnt", int'(cnt), 0);

    // Counter: threshold 0 gates on the second edge after entry
    step(0, 0, 0, 0, 1, 4'd0, 0);
    step(1, 1, 0, 0, 1, 4'd0, 0);   // enter IDLE_CNT
    step(1, 1, 0, 0, 1, 4'd0, 0);   // go GATED
    check("thr0_clk_en_pre", int'(clk_en), 1);
    step(1, 1, 0, 0, 1, 4'd0, 0);
    check("thr0_clk_en", int'(clk_en), 0);
    check("thr0_cnt",    int'(cnt),    1);
    for (int i = 0; i < 9; i++) step(1, 1, 0, 0, 1, 4'd0, 0);
    check("cnt_10", int'(cnt), 10);
    step(1, 1, 0, 0, 1, 4'd0, 1);
    check("cnt_clear", int'(cnt), 0);
    step(1, 1, 0, 0, 1, 4'd0, 0);
    check("cnt_resume1", int'(cnt), 1);
    step(1, 1, 0, 0, 1, 4'd0, 0);
    check("cnt_resume2", int'(cnt), 2);

    // Saturation on the 4-bit instance after 20 gated cycles
    step(0, 0, 0, 0, 1, 4'd0, 0);
    step(1, 1, 0, 0, 1, 4'd0, 0);
    step(1, 1, 0, 0, 1, 4'd0, 0);
    for (int i = 0; i < 20; i++) step(1, 1, 0, 0, 1, 4'd0, 0);
    check("sat_cnt16", int'(cnt),  20);
    check("sat_cnt4",  int'(cnt2), 15);

    // Reset mid-sleep: single reset edge while gated
    step(0, 1, 0, 0, 1, 4'd0, 0);
    check("rst_gated_clk_en", int'(clk_en),   1);
    check("rst_gated_gated",  int'(gated),    0);
    check("rst_gated_ack",    int'(wake_ack), 0);
    check("rst_gated_cnt",    int'(cnt),      0);
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 0, 0, 1, 4'd0, 0);
      check("rst_gated_no_ack", int'(wake_ack), 0);
    end

    // Randomized phase against the reference model
    begin
      logic [IDLE_W-1:0] rt;
      rt = 4'd2;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 29) == 0) rt = IDLE_W'($urandom_range(0, 6));
        step(($urandom_range(0, 199) != 0),
             ($urandom_range(0, 9) < 8),
             ($urandom_range(0, 9) == 0),
             ($urandom_range(0, 14) == 0),
             ($urandom_range(0, 19) != 0),
             rt,
             ($urandom_range(0, 59) == 0));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/cv32e40p_clock_gate_ctrl.md
CV32E40P_CLOCK_GATE_CTRL -- requirements
Module: cv32e40p_clock_gate_ctrl

Interface
REQ-001 SHALL have parameter IDLE_W, default 4: width of idle_thresh_i and the idle counter.
REQ-002 SHALL have parameter WAKE_DLY, default 2: extra WAKE cycles before wake_ack_o, range 0..15.
REQ-003 SHALL have parameter CNT_W, default 16: width of sleep_cycles_o.
REQ-004 SHALL have port clk_i, input, 1: free-running (ungated) clock.
REQ-005 SHALL have port rst_ni, input, 1: reset, synchronous to clk_i and active-low.
REQ-006 SHALL have port core_sleep_req_i, input, 1: core is in WFI and requests sleep.
REQ-007 SHALL have port core_busy_i, input, 1: core has outstanding activity and gating is forbidden.
REQ-008 SHALL have port wake_req_i, input, 1: pending interrupt or debug request.
REQ-009 SHALL have port gate_allow_i, input, 1: global enable for clock gating.
REQ-010 SHALL have port idle_thresh_i, input, IDLE_W: idle cycles required before gating.
REQ-011 SHALL have port clear_cnt_i, input, 1: synchronous clear of sleep_cycles_o.
REQ-012 SHALL have port clk_en_o, output, 1: enable to the downstream core clock gate's en_i.
REQ-013 SHALL have port gated_o, output, 1: core clock is currently gated.
REQ-014 SHALL have port wake_ack_o, output, 1: single-cycle pulse when the woken clock is stable.
REQ-015 SHALL have port sleep_cycles_o, output, CNT_W: saturating count of GATED cycles.

Function
REQ-016 SHALL implement FSM states RUN, IDLE_CNT, GATED and WAKE; all outputs SHALL be registered.
REQ-017 SHALL drive clk_en_o=0 only in GATED and clk_en_o=1 in all other states.
REQ-018 SHALL drive gated_o=1 only in GATED.
REQ-019 RUN: if gate_allow_i & core_sleep_req_i & ~core_busy_i & ~wake_req_i, the FSM SHALL go to IDLE_CNT with idle_cnt=0; otherwise it SHALL stay in RUN.
REQ-020 IDLE_CNT abort: if any RUN entry condition is false, the FSM SHALL return to RUN.
REQ-021 IDLE_CNT no abort: if idle_cnt >= idle_thresh_i, the FSM SHALL go to GATED; otherwise idle_cnt SHALL increment.
REQ-022 Abort SHALL take priority over reaching the threshold.
REQ-023 idle_thresh_i SHALL be sampled every cycle; a change in value SHALL take effect immediately.
REQ-024 idle_thresh_i=0 SHALL cause gating on the second edge after IDLE_CNT entry.
REQ-025 idle_cnt SHALL saturate at all-ones and never wrap.
REQ-026 GATED: if wake_req_i | ~gate_allow_i | ~core_sleep_req_i, the FSM SHALL go to WAKE with wake_cnt=0.
REQ-027 core_busy_i SHALL be ignored in GATED.
REQ-028 WAKE: if wake_cnt==WAKE_DLY, the FSM SHALL go to RUN and assert wake_ack_o for exactly one cycle (the first RUN cycle); otherwise wake_cnt SHALL increment.
REQ-029 wake_req_i SHALL be ignored during WAKE.
REQ-030 WAKE SHALL never return directly to GATED.
REQ-031 Every GATED-to-RUN sequence SHALL produce exactly one wake_ack_o pulse; no other path SHALL pulse wake_ack_o.
REQ-032 sleep_cycles_o SHALL increment by 1 for each cycle in GATED and SHALL saturate at 2^CNT_W-1.
REQ-033 clear_cnt_i SHALL take priority over increment, giving 0 on the next cycle.
REQ-034 clk_en_o SHALL be glitch-free, as a direct flop output with no combinational path from inputs.

Reset
REQ-035 On rst_ni=0 at a clk_i edge, the block SHALL set state=RUN, clk_en_o=1, gated_o=0, wake_ack_o=0, idle_cnt=0, wake_cnt=0 and sleep_cycles_o=0.
REQ-036 Reset asserted in GATED or WAKE SHALL restore clk_en_o=1 on that edge, with no wake_ack_o pulse.
REQ-037 Reset SHALL override all inputs, including clear_cnt_i.

Verification
REQ-038 Basic gating: idle_thresh_i=3, with sleep_req=1, busy=0 and allow=1 first sampled at edge 0 -> IDLE_CNT at edge 1, clk_en_o=0 and gated_o=1 from edge 5.
REQ-039 Wake: in GATED, wake_req_i=1 sampled at edge g with WAKE_DLY=2 -> clk_en_o=1 at g+1, wake_ack_o=1 only during g+4..g+5, RUN at g+4.
REQ-040 Abort: core_busy_i pulses in IDLE_CNT on the same edge the threshold is reached -> RUN, clk_en_o never drops, sleep_cycles_o unchanged.
REQ-041 Counter: 10 GATED cycles -> sleep_cycles_o=10; clear_cnt_i=1 asserted during GATED -> 0 on the next cycle, then it resumes incrementing.
REQ-042 Saturation: CNT_W=4, 20 GATED cycles -> sleep_cycles_o=15.
REQ-043 Reset mid-sleep: rst_ni=0 for one edge in GATED -> clk_en_o=1 and gated_o=0 on that edge, wake_ack_o stays 0, sleep_cycles_o=0.
